// File: rtl/branch_hazard_sequencer.sv
// Purpose: ID-stage control-transfer sequencer. Holds PC and IF/ID while a
//          branch/jr source register is still being produced in EX or MEM.
//          It then passes the resolver's redirect through and flushes the
//          wrong-path instruction. It also keeps saturating counters of taken
//          redirects and stall cycles.
// Ports:
//   i_clk, i_rst        rising-edge clock, async active-high reset
//   i_id_instruction    instruction held in IF/ID
//   i_pcsel_in          redirect request from the branch/jump resolver
//   i_ex_*              ID/EX producer info (reg write, load, destination)
//   i_mem_*             EX/MEM producer info (load, destination)
//   o_*_c               Mealy control outputs (PC/IF-ID enables, flush, bubble,
//                       gated redirect select)
//   o_taken_count       saturating count of issued redirects
//   o_stall_count       saturating count of stall cycles
module branch_hazard_sequencer #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [31:0]          i_id_instruction,
   input  logic                 i_pcsel_in,
   input  logic                 i_ex_reg_write,
   input  logic                 i_ex_mem_read,
   input  logic [4:0]           i_ex_write_reg,
   input  logic                 i_mem_mem_read,
   input  logic [4:0]           i_mem_write_reg,
   output logic                 o_pc_write_c,
   output logic                 o_ifid_write_c,
   output logic                 o_ifid_flush_c,
   output logic                 o_idex_bubble_c,
   output logic                 o_pcsel_out_c,
   output logic [CNT_WIDTH-1:0] o_taken_count,
   output logic [CNT_WIDTH-1:0] o_stall_count
);

   localparam int unsigned OP_W  = 6;
   localparam int unsigned REG_W = 5;

   localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
   localparam logic [OP_W-1:0] OP_REGIMM  = 6'b000001;
   localparam logic [OP_W-1:0] OP_J       = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;
   localparam logic [OP_W-1:0] OP_BLEZ    = 6'b000110;
   localparam logic [OP_W-1:0] OP_BGTZ    = 6'b000111;
   localparam logic [OP_W-1:0] FN_JR      = 6'b001000;

   typedef enum logic {ST_IDLE, ST_STALL} state_t;

   state_t               r_state;
   logic [1:0]           r_cnt;
   logic [CNT_WIDTH-1:0] r_taken_count;
   logic [CNT_WIDTH-1:0] r_stall_count;

   logic [OP_W-1:0]  w_op;
   logic [OP_W-1:0]  w_funct;
   logic [REG_W-1:0] w_rs;
   logic [REG_W-1:0] w_rt;
   logic             w_ct;
   logic             w_use_rs;
   logic             w_use_rt;
   logic             w_ex_match;
   logic             w_mem_match;
   logic             w_haz;
   logic             w_long;
   logic             w_stall;
   logic             w_unused;

   assign w_op     = i_id_instruction[31:26];
   assign w_rs     = i_id_instruction[25:21];
   assign w_rt     = i_id_instruction[20:16];
   assign w_funct  = i_id_instruction[5:0];
   assign w_unused = ^i_id_instruction[15:6];

   // Control-transfer decode and which source registers it reads
   always_comb begin
      w_use_rs = 1'b0;
      w_use_rt = 1'b0;
      w_ct     = 1'b0;
      unique case (w_op)
         OP_SPECIAL: begin
            w_ct     = (w_funct == FN_JR);
            w_use_rs = w_ct;
         end
         OP_REGIMM: begin
            w_ct     = (w_rt[4:1] == 4'b0000);
            w_use_rs = w_ct;
         end
         OP_BEQ, OP_BNE: begin
            w_ct     = 1'b1;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
         end
         OP_BLEZ, OP_BGTZ: begin
            w_ct     = 1'b1;
            w_use_rs = 1'b1;
         end
         OP_J, OP_JAL: w_ct = 1'b1;
         default: ;
      endcase
   end

   // Producer matches; $0 is never a dependency
   always_comb begin
      w_ex_match  = 1'b0;
      w_mem_match = 1'b0;
      if (w_use_rs && (w_rs != '0)) begin
         w_ex_match  = w_ex_match  | (i_ex_reg_write && (i_ex_write_reg == w_rs));
         w_mem_match = w_mem_match | (i_mem_mem_read && (i_mem_write_reg == w_rs));
      end
      if (w_use_rt && (w_rt != '0)) begin
         w_ex_match  = w_ex_match  | (i_ex_reg_write && (i_ex_write_reg == w_rt));
         w_mem_match = w_mem_match | (i_mem_mem_read && (i_mem_write_reg == w_rt));
      end
   end

   assign w_haz  = w_ct && (w_ex_match || w_mem_match);
   // A load still in EX needs two cycles before its value can be forwarded
   assign w_long = w_ex_match && i_ex_mem_read;

   // Mealy controls; reset forces the pass-through, non-redirecting state
   always_comb begin
      w_stall         = 1'b0;
      o_pc_write_c    = 1'b1;
      o_ifid_write_c  = 1'b1;
      o_ifid_flush_c  = 1'b0;
      o_idex_bubble_c = 1'b0;
      o_pcsel_out_c   = 1'b0;
      if (!i_rst) begin
         w_stall = (r_state == ST_STALL) || w_haz;
         if (w_stall) begin
            o_pc_write_c    = 1'b0;
            o_ifid_write_c  = 1'b0;
            o_idex_bubble_c = 1'b1;
         end else begin
            o_pcsel_out_c  = i_pcsel_in;
            o_ifid_flush_c = i_pcsel_in;
         end
      end
   end

   // State, stall counter and saturating performance counters
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 2'd0;
         r_taken_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + CNT_WIDTH'(1);
         unique case (r_state)
            ST_IDLE: begin
               if (w_haz) begin
                  r_cnt   <= w_long ? 2'd1 : 2'd0;
                  r_state <= w_long ? ST_STALL : ST_IDLE;
               end else if (i_pcsel_in && (r_taken_count != '1)) begin
                  r_taken_count <= r_taken_count + CNT_WIDTH'(1);
               end
            end
            ST_STALL: begin
               r_cnt <= r_cnt - 2'd1;
               // cnt<=1 rather than ==1 so a corrupted cnt cannot lock the stall
               if (r_cnt <= 2'd1)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_taken_count = r_taken_count;
   assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// Purpose: self-checking bench for branch_hazard_sequencer (CNT_WIDTH=4 build).
//          Each vector's expected outputs go into a scoreboard queue when the
//          vector is driven and are popped and compared mid-cycle.
module tb_branch_hazard_sequencer;

   localparam int unsigned CW = 4;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        pcsel;
      logic        exrw;
      logic        exmr;
      logic [4:0]  exwr;
      logic        memmr;
      logic [4:0]  memwr;
   } stim_t;

   typedef struct packed {
      logic          pcw;
      logic          ifw;
      logic          flush;
      logic          bub;
      logic          sel;
      logic [CW-1:0] taken;
      logic [CW-1:0] stall;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [31:0]   instr;
   logic          pcsel_in;
   logic          ex_rw;
   logic          ex_mr;
   logic [4:0]    ex_wr;
   logic          mem_mr;
   logic [4:0]    mem_wr;
   logic          pc_write;
   logic          ifid_write;
   logic          ifid_flush;
   logic          idex_bubble;
   logic          pcsel_out;
   logic [CW-1:0] taken_count;
   logic [CW-1:0] stall_count;

   exp_t sb_q[$];
   int   n_vec;
   int   n_err;

   branch_hazard_sequencer #(.CNT_WIDTH(CW)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_id_instruction (instr),
      .i_pcsel_in       (pcsel_in),
      .i_ex_reg_write   (ex_rw),
      .i_ex_mem_read    (ex_mr),
      .i_ex_write_reg   (ex_wr),
      .i_mem_mem_read   (mem_mr),
      .i_mem_write_reg  (mem_wr),
      .o_pc_write_c     (pc_write),
      .o_ifid_write_c   (ifid_write),
      .o_ifid_flush_c   (ifid_flush),
      .o_idex_bubble_c  (idex_bubble),
      .o_pcsel_out_c    (pcsel_out),
      .o_taken_count    (taken_count),
      .o_stall_count    (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   // Instruction encodings used below
   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [31:0] BEQ_1_2  = {6'd4, 5'd1, 5'd2, 16'h0010};
   localparam logic [31:0] BNE_3_4  = {6'd5, 5'd3, 5'd4, 16'h0008};
   localparam logic [31:0] BGTZ_5   = {6'd7, 5'd5, 5'd0, 16'h0004};
   localparam logic [31:0] BGTZ_5_9 = {6'd7, 5'd5, 5'd9, 16'h0004};
   localparam logic [31:0] BLTZ_6   = {6'd1, 5'd6, 5'd0, 16'h0004};
   localparam logic [31:0] BGEZ_7   = {6'd1, 5'd7, 5'd1, 16'h0004};
   localparam logic [31:0] RI_6_RT2 = {6'd1, 5'd6, 5'd2, 16'h0004};
   localparam logic [31:0] JR_0     = {6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd8};
   localparam logic [31:0] J_40     = {6'd2, 26'h000_0040};
   localparam logic [31:0] ADD_3_1_2 = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};

   function automatic stim_t mk(input logic r, input logic [31:0] in, input logic ps,
                                input logic erw, input logic emr, input logic [4:0] ewr,
                                input logic mmr, input logic [4:0] mwr);
      stim_t s;
      s.rst = r; s.instr = in; s.pcsel = ps;
      s.exrw = erw; s.exmr = emr; s.exwr = ewr;
      s.memmr = mmr; s.memwr = mwr;
      return s;
   endfunction

   // Normal (pass-through) expectation
   function automatic exp_t nrm(input logic ps, input int t, input int st);
      exp_t e;
      e.pcw = 1'b1; e.ifw = 1'b1; e.flush = ps; e.bub = 1'b0; e.sel = ps;
      e.taken = CW'(t); e.stall = CW'(st);
      return e;
   endfunction

   // Stall expectation
   function automatic exp_t stl(input int t, input int st);
      exp_t e;
      e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b0; e.bub = 1'b1; e.sel = 1'b0;
      e.taken = CW'(t); e.stall = CW'(st);
      return e;
   endfunction

   task automatic drive(input stim_t s, input exp_t e);
      @(posedge clk);
      #1;
      rst = s.rst; instr = s.instr; pcsel_in = s.pcsel;
      ex_rw = s.exrw; ex_mr = s.exmr; ex_wr = s.exwr;
      mem_mr = s.memmr; mem_wr = s.memwr;
      sb_q.push_back(e);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; instr = NOP; pcsel_in = 1'b0;
      ex_rw = 1'b0; ex_mr = 1'b0; ex_wr = 5'd0; mem_mr = 1'b0; mem_wr = 5'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reset outputs, counters cleared, and evaluation starting in IDLE on release
   task automatic test_reset();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      sv.push_back(mk(1, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(nrm(0, 0, 0));
      sv.push_back(mk(0, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(stl(0, 0));
      sv.push_back(mk(0, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(stl(0, 1));
      sv.push_back(mk(0, BNE_3_4, 1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(1, 0, 2));
      sv.push_back(mk(0, NOP,     0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 2));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   // Hazard-free beq: same-cycle redirect and flush, taken counter increments
   task automatic test_taken();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      apply_reset();
      sv.push_back(mk(0, BEQ_1_2, 1, 1, 0, 5'd3, 1, 5'd5)); ev.push_back(nrm(1, 0, 0));
      sv.push_back(mk(0, NOP,     0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 0));
      sv.push_back(mk(0, BEQ_1_2, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 0));
      sv.push_back(mk(0, NOP,     0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 0));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL taken[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   // Two-cycle EX-load stall and one-cycle EX-ALU stall, then redirect
   task automatic test_stalls();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      apply_reset();
      sv.push_back(mk(0, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(stl(0, 0));
      sv.push_back(mk(0, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(stl(0, 1));
      sv.push_back(mk(0, BNE_3_4, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 0, 2));
      sv.push_back(mk(0, NOP,     0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 0, 2));
      sv.push_back(mk(0, BGTZ_5,  1, 1, 0, 5'd5, 0, 5'd0)); ev.push_back(stl(0, 2));
      sv.push_back(mk(0, BGTZ_5,  1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(1, 0, 3));
      sv.push_back(mk(0, NOP,     0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 3));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL stalls[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   // Mixed matches, residual hazards, regimm decode and non-CT instructions
   task automatic test_combos();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      apply_reset();
      sv.push_back(mk(0, BEQ_1_2,  1, 1, 0, 5'd1, 1, 5'd2)); ev.push_back(stl(0, 0));
      sv.push_back(mk(0, BEQ_1_2,  1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(1, 0, 1));
      sv.push_back(mk(0, BNE_3_4,  1, 1, 1, 5'd3, 1, 5'd4)); ev.push_back(stl(1, 1));
      sv.push_back(mk(0, BNE_3_4,  1, 1, 1, 5'd3, 1, 5'd4)); ev.push_back(stl(1, 2));
      sv.push_back(mk(0, BNE_3_4,  0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 3));
      sv.push_back(mk(0, BGTZ_5,   0, 1, 0, 5'd5, 0, 5'd0)); ev.push_back(stl(1, 3));
      sv.push_back(mk(0, BGTZ_5,   0, 0, 0, 5'd0, 1, 5'd5)); ev.push_back(stl(1, 4));
      sv.push_back(mk(0, BGTZ_5,   1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(1, 1, 5));
      sv.push_back(mk(0, BLTZ_6,   0, 0, 0, 5'd0, 1, 5'd6)); ev.push_back(stl(2, 5));
      sv.push_back(mk(0, BLTZ_6,   0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 2, 6));
      sv.push_back(mk(0, RI_6_RT2, 0, 0, 0, 5'd0, 1, 5'd6)); ev.push_back(nrm(0, 2, 6));
      sv.push_back(mk(0, BEQ_1_2,  0, 0, 1, 5'd1, 0, 5'd1)); ev.push_back(nrm(0, 2, 6));
      sv.push_back(mk(0, ADD_3_1_2,0, 1, 1, 5'd1, 1, 5'd2)); ev.push_back(nrm(0, 2, 6));
      sv.push_back(mk(0, BGEZ_7,   0, 1, 0, 5'd7, 0, 5'd0)); ev.push_back(stl(2, 6));
      sv.push_back(mk(0, BGEZ_7,   0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 2, 7));
      sv.push_back(mk(0, BGTZ_5_9, 0, 1, 0, 5'd9, 1, 5'd9)); ev.push_back(nrm(0, 2, 7));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL combos[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   // $0 never stalls; j never stalls
   task automatic test_zero_and_jump();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      apply_reset();
      sv.push_back(mk(0, JR_0, 1, 1, 1, 5'd0, 1, 5'd0)); ev.push_back(nrm(1, 0, 0));
      sv.push_back(mk(0, NOP,  0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 1, 0));
      sv.push_back(mk(0, J_40, 1, 1, 1, 5'd0, 1, 5'd0)); ev.push_back(nrm(1, 1, 0));
      sv.push_back(mk(0, NOP,  0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 2, 0));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL zero_jump[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   // Reset raised mid-cycle during a load stall takes effect without a clock edge
   task automatic test_reset_mid_stall();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      apply_reset();
      sv.push_back(mk(0, BEQ_1_2, 1, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(1, 0, 0));
      sv.push_back(mk(0, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(stl(1, 0));
      sv.push_back(mk(1, BNE_3_4, 1, 1, 1, 5'd4, 0, 5'd0)); ev.push_back(nrm(0, 0, 0));
      sv.push_back(mk(0, NOP,     0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 0, 0));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset_mid_stall[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   // Both counters saturate at all-ones
   task automatic test_saturate();
      stim_t sv[$];
      exp_t  ev[$];
      exp_t  got;
      exp_t  want;
      int    smax;
      smax = (1 << CW) - 1;
      apply_reset();
      for (int k = 0; k < 18; k++) begin
         sv.push_back(mk(0, BGTZ_5, 0, 1, 0, 5'd5, 0, 5'd0));
         ev.push_back(stl(0, (k < smax) ? k : smax));
      end
      sv.push_back(mk(0, NOP, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, 0, smax));
      for (int k = 0; k < 18; k++) begin
         sv.push_back(mk(0, BEQ_1_2, 1, 0, 0, 5'd0, 0, 5'd0));
         ev.push_back(nrm(1, (k < smax) ? k : smax, smax));
      end
      sv.push_back(mk(0, NOP, 0, 0, 0, 5'd0, 0, 5'd0)); ev.push_back(nrm(0, smax, smax));
      for (int i = 0; i < sv.size(); i++) begin
         drive(sv[i], ev[i]);
         @(negedge clk);
         got  = {pc_write, ifid_write, ifid_flush, idex_bubble, pcsel_out, taken_count, stall_count};
         want = sb_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL saturate[%0d]: got pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d, want pcw=%b ifw=%b flush=%b bub=%b sel=%b taken=%0d stall=%0d",
                     i, got.pcw, got.ifw, got.flush, got.bub, got.sel, got.taken, got.stall,
                     want.pcw, want.ifw, want.flush, want.bub, want.sel, want.taken, want.stall);
         end
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      instr    = NOP;
      pcsel_in = 1'b0;
      ex_rw    = 1'b0;
      ex_mr    = 1'b0;
      ex_wr    = 5'd0;
      mem_mr   = 1'b0;
      mem_wr   = 5'd0;
      test_reset();
      test_taken();
      test_stalls();
      test_combos();
      test_zero_and_jump();
      test_reset_mid_stall();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_hazard_sequencer.md
# branch_hazard_sequencer

Sequences ID-stage control transfers: branches, jr, j and jal. The block sits between the combinational branch/jump resolver and the pipeline registers. It holds PC and IF/ID while a branch's source operands are still being produced downstream, then forwards the resolver's redirect and flushes the wrong-path instruction. It also keeps saturating counters of taken redirects and stall cycles for performance readout.

## Interface
- CNT_WIDTH, 16, width of both performance counters
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears state and counters
- ID_Instruction  input  32  instruction currently in IF/ID
- PCSel_In  input  1  redirect request from the branch/jump resolver, combinational on ID operands
- EX_RegWrite  input  1  instruction in ID/EX writes a register
- EX_MemRead  input  1  instruction in ID/EX is a load
- EX_WriteReg  input  5  destination register of the ID/EX instruction
- MEM_MemRead  input  1  instruction in EX/MEM is a load
- MEM_WriteReg  input  5  destination register of the EX/MEM instruction
- PCWrite  output  1  PC register load enable
- IFID_Write  output  1  IF/ID load enable
- IFID_Flush  output  1  zero IF/ID on the next edge
- IDEX_Bubble  output  1  force ID/EX control fields to zero
- PCSel_Out  output  1  gated redirect select for the PC mux
- Taken_Count  output  CNT_WIDTH  number of redirects issued
- Stall_Count  output  CNT_WIDTH  number of stall cycles

## Operation
- Decode, from ID_Instruction:
  - CT (control transfer): any of the following.
  - op=000000 with funct=001000 (jr): uses rs.
  - op=000001 with rt∈{00000,00001}: uses rs.
  - op=000100 or 000101: uses rs and rt.
  - op=000110 or 000111: uses rs.
  - op=000010 or 000011 (j/jal): uses no registers.
- Match on register r, defined only for r≠0 and r a used source:
  - (EX_RegWrite && EX_WriteReg==r), or
  - (MEM_MemRead && MEM_WriteReg==r).
- HAZ = CT && any match.
- Stall length: 2 if the EX match has EX_MemRead=1. Otherwise 1 (EX ALU result, or MEM load).
- State machine has two states, IDLE and STALL, plus a 2-bit cnt.
- IDLE, no CT or CT without HAZ (normal):
  - PCWrite=1, IFID_Write=1, IDEX_Bubble=0.
  - PCSel_Out=PCSel_In and IFID_Flush=PCSel_In.
  - If PCSel_In=1, Taken_Count increments.
- IDLE with HAZ:
  - PCWrite=0, IFID_Write=0, IDEX_Bubble=1, PCSel_Out=0, IFID_Flush=0.
  - cnt ← stall length − 1.
  - Next state is STALL if stall length is 2, otherwise IDLE.
  - Stall_Count increments.
- STALL:
  - Outputs are the same as IDLE with HAZ; PCSel_In is ignored.
  - Stall_Count increments and cnt decrements.
  - When cnt==1 on entry, the next state is IDLE.
- On return to IDLE, the branch is re-evaluated. A residual HAZ stalls again; no hazard is ever bypassed.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (async, immediate):
  - State=IDLE, cnt=0, Taken_Count=0, Stall_Count=0.
  - Outputs while Reset=1: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, PCSel_Out=0.
- Control outputs are Mealy: combinational from state and the current-cycle inputs, with zero latency.
- State, cnt and counters update on the rising Clk edge.
- Redirect latency: PCSel_Out is asserted in the same cycle the CT is hazard-free and PCSel_In=1. The target is loaded on that edge, and the fall-through instruction is flushed on that edge.
- No delay slot: a taken CT always flushes IF/ID.
- Stall cost:
  - EX-load dependency: 2 cycles.
  - EX-ALU dependency: 1 cycle.
  - MEM-load dependency: 1 cycle.
  - Each stall is followed by one resolving cycle.
- Simultaneous EX-ALU and MEM-load matches: 1 stall.
- Simultaneous EX-load and MEM match: 2 stalls.
- Register $0 never causes a stall.
- j and jal never stall.
- Reset asserted mid-STALL aborts the stall immediately; counters clear.
- Reset releasing while IF/ID holds a CT: evaluation starts in IDLE on the first cycle.

## Test plan
- beq $1,$2 with PCSel_In=1 and no matching EX/MEM destinations:
  - Same cycle: PCSel_Out=1, IFID_Flush=1, PCWrite=1.
  - Taken_Count 0→1.
- bne $3,$4 with EX_MemRead=1, EX_RegWrite=1, EX_WriteReg=4:
  - Two cycles with PCWrite=0, IDEX_Bubble=1.
  - Third cycle: IDLE, normal outputs.
  - Stall_Count=2.
- bgtz $5 with EX_RegWrite=1, EX_WriteReg=5 (not a load):
  - Exactly one stall cycle, then redirect when PCSel_In=1.
- jr $0 with EX_WriteReg=0, EX_RegWrite=1:
  - No stall.
- j 0x0040 with every EX/MEM destination matching:
  - No stall; PCSel_Out=PCSel_In=1.
- Reset asserted during the first cycle of a 2-cycle load stall:
  - Outputs return to PCWrite=1, IDEX_Bubble=0 without waiting for Clk.
  - Both counters read 0.
- Preload Stall_Count to all-ones via repeated stalls (CNT_WIDTH=4 build), then one more stall:
  - Stall_Count stays 15.
